// File: rtl/divider_core.sv
// Programmable clock divider: div_out has a period of active_ratio clocks, high for ceil(N/2) of them.
// Latency: all outputs are registered; a load made in IDLE is acknowledged next cycle and RUN starts one cycle later.
// Backpressure: none; a new ratio waits in a pending register until the next period boundary, and a later load replaces it.
module divider_core #(
    parameter int WIDTH = 32
) (
    input  logic             div_clock,
    input  logic             div_reset,
    input  logic [WIDTH-1:0] ratio_in,
    input  logic             ratio_load,
    input  logic             div_enable,
    output logic             div_out,
    output logic             div_tick,
    output logic             ratio_ack,
    output logic             ratio_err,
    output logic             running,
    output logic [WIDTH-1:0] active_ratio
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] active_q,  active_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             pend_vld_q, pend_vld_d;
    logic             div_out_q, div_out_d;
    logic             div_tick_q, div_tick_d;
    logic             ack_q,     ack_d;
    logic             err_q,     err_d;

    logic             load_ok;
    logic             wrap;
    logic [WIDTH-1:0] half_d;

    // Next-state, ratio bookkeeping and registered output values.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;
        // Ratio 1 cannot produce a divided clock, so it is rejected outright.
        err_d      = ratio_load && (ratio_in == WIDTH'(1));
        load_ok    = ratio_load && (ratio_in != WIDTH'(1));
        // Only meaningful in RUN, where active_q >= 2.
        wrap       = (count_q == (active_q - WIDTH'(1)));

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (load_ok) begin
                    // No period to protect: a fresh load goes straight to active.
                    active_d   = ratio_in;
                    ack_d      = 1'b1;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    // Left over from a load made in RUN before a disable.
                    active_d   = pending_q;
                    ack_d      = 1'b1;
                    pend_vld_d = 1'b0;
                end else if (div_enable && (active_q >= WIDTH'(2))) begin
                    // Start only once no apply is in flight, so the first
                    // period always runs under a stable ratio.
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load_ok) begin
                    pending_d  = ratio_in;
                    pend_vld_d = 1'b1;
                end
                if (!div_enable) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (wrap) begin
                    count_d = '0;
                    if (pend_vld_q) begin
                        // A load on this same edge stays pending for the next wrap.
                        active_d = pending_q;
                        ack_d    = 1'b1;
                        if (!load_ok) begin
                            pend_vld_d = 1'b0;
                        end
                        if (pending_q < WIDTH'(2)) begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        // ceil(N/2) without overflow even for N = 2^WIDTH-1.
        half_d     = (active_d >> 1) + {{(WIDTH-1){1'b0}}, active_d[0]};
        div_out_d  = (state_d == RUN) && (count_d < half_d);
        div_tick_d = (state_d == RUN) && (count_d == '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge div_clock) begin
        if (div_reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            div_out_q  <= 1'b0;
            div_tick_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            div_out_q  <= div_out_d;
            div_tick_q <= div_tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign div_out      = div_out_q;
    assign div_tick     = div_tick_q;
    assign ratio_ack    = ack_q;
    assign ratio_err    = err_q;
    assign running      = (state_q == RUN);
    assign active_ratio = active_q;

endmodule

// File: tb/tb_divider_core.sv
// Directed bench for divider_core with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
// All comparisons go through check(); the summary reports checks and failures.
module tb_divider_core;

    localparam int WIDTH = 32;

    logic             div_clock = 1'b0;
    logic             div_reset;
    logic [WIDTH-1:0] ratio_in;
    logic             ratio_load;
    logic             div_enable;
    logic             div_out;
    logic             div_tick;
    logic             ratio_ack;
    logic             ratio_err;
    logic             running;
    logic [WIDTH-1:0] active_ratio;

    int n_checks = 0;
    int n_fail   = 0;

    int pat4 [4] = '{1, 1, 0, 0};
    int pat5 [5] = '{1, 1, 1, 0, 0};

    divider_core #(.WIDTH(WIDTH)) dut (
        .div_clock    (div_clock),
        .div_reset    (div_reset),
        .ratio_in     (ratio_in),
        .ratio_load   (ratio_load),
        .div_enable   (div_enable),
        .div_out      (div_out),
        .div_tick     (div_tick),
        .ratio_ack    (ratio_ack),
        .ratio_err    (ratio_err),
        .running      (running),
        .active_ratio (active_ratio)
    );

    always #5 div_clock = ~div_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge div_clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int lo;
        int saw_ack;

        div_reset  = 1'b1;
        ratio_in   = '0;
        ratio_load = 1'b0;
        div_enable = 1'b0;
        step();
        step();
        div_reset = 1'b0;
        check("rst_out",    32'(div_out), 0);
        check("rst_tick",   32'(div_tick), 0);
        check("rst_ack",    32'(ratio_ack), 0);
        check("rst_err",    32'(ratio_err), 0);
        check("rst_run",    32'(running), 0);
        check("rst_active", active_ratio, 0);

        // Load 4 in IDLE: ack next cycle, RUN the cycle after.
        div_enable = 1'b1;
        ratio_in   = 32'd4;
        ratio_load = 1'b1;
        step();
        ratio_load = 1'b0;
        check("l4_ack",    32'(ratio_ack), 1);
        check("l4_active", active_ratio, 4);
        check("l4_idle",   32'(running), 0);
        check("l4_out0",   32'(div_out), 0);
        step();
        check("l4_run",  32'(running), 1);
        check("l4_ack0", 32'(ratio_ack), 0);
        for (int i = 0; i < 8; i++) begin
            check("n4_out",  32'(div_out), 32'(pat4[i % 4]));
            check("n4_tick", 32'(div_tick), ((i % 4) == 0) ? 32'd1 : 32'd0);
            step();
        end

        // Load 5 mid-period: current period of 4 completes first.
        step();                       // c=1
        ratio_in   = 32'd5;
        ratio_load = 1'b1;
        step();                       // c=2
        ratio_load = 1'b0;
        check("l5_keep4", active_ratio, 4);
        check("l5_noack", 32'(ratio_ack), 0);
        step();                       // c=3
        check("l5_c3out", 32'(div_out), 0);
        step();                       // new period
        check("l5_ack",    32'(ratio_ack), 1);
        check("l5_active", active_ratio, 5);
        for (int i = 0; i < 5; i++) begin
            check("n5_out",  32'(div_out), 32'(pat5[i]));
            check("n5_tick", 32'(div_tick), (i == 0) ? 32'd1 : 32'd0);
            if (i > 0) check("n5_ack1", 32'(ratio_ack), 0);
            step();
        end

        // Back to 4 at c=0 of an N=5 period.
        ratio_in   = 32'd4;
        ratio_load = 1'b1;
        step();
        ratio_load = 1'b0;
        repeat (4) step();
        check("b4_ack",    32'(ratio_ack), 1);
        check("b4_active", active_ratio, 4);

        // Ratio 1 is rejected.
        ratio_in   = 32'd1;
        ratio_load = 1'b1;
        step();                       // c=1
        ratio_load = 1'b0;
        check("r1_err", 32'(ratio_err), 1);
        check("r1_ack", 32'(ratio_ack), 0);
        step();
        check("r1_err0", 32'(ratio_err), 0);
        step();
        step();                       // c=0
        check("r1_noack",  32'(ratio_ack), 0);
        check("r1_tick",   32'(div_tick), 1);
        check("r1_active", active_ratio, 4);

        // 32000: load at c=0, applies at the wrap.
        ratio_in   = 32'd32000;
        ratio_load = 1'b1;
        step();
        ratio_load = 1'b0;
        repeat (3) step();
        check("big_ack",    32'(ratio_ack), 1);
        check("big_active", active_ratio, 32000);
        check("big_tick",   32'(div_tick), 1);
        // Load 0 at c=0; it takes effect at this period's wrap.
        ratio_in   = 32'd0;
        ratio_load = 1'b1;
        hi = 0;
        while (div_out == 1'b1 && hi < 40000) begin
            hi++;
            step();
            ratio_load = 1'b0;
        end
        lo = 0;
        while (div_out == 1'b0 && running == 1'b1 && lo < 40000) begin
            lo++;
            step();
        end
        check("big_hi",     32'(hi), 16000);
        check("big_lo",     32'(lo), 16000);
        check("z_run",      32'(running), 0);
        check("z_out",      32'(div_out), 0);
        check("z_active",   active_ratio, 0);

        // Reset at c=2 of N=6 with 60000 pending.
        ratio_in   = 32'd6;
        ratio_load = 1'b1;
        step();
        ratio_load = 1'b0;
        check("l6_ack", 32'(ratio_ack), 1);
        step();                       // c=0
        check("l6_tick", 32'(div_tick), 1);
        step();                       // c=1
        ratio_in   = 32'd60000;
        ratio_load = 1'b1;
        step();                       // c=2
        ratio_load = 1'b0;
        check("l6_c2out", 32'(div_out), 1);
        div_reset = 1'b1;
        step();
        div_reset = 1'b0;
        check("mr_out",    32'(div_out), 0);
        check("mr_tick",   32'(div_tick), 0);
        check("mr_ack",    32'(ratio_ack), 0);
        check("mr_run",    32'(running), 0);
        check("mr_active", active_ratio, 0);
        saw_ack = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ratio_ack || running) saw_ack = 1;
        end
        check("mr_noack", 32'(saw_ack), 0);

        // Disable at c=1 of N=4 for 3 cycles.
        ratio_in   = 32'd4;
        ratio_load = 1'b1;
        step();
        ratio_load = 1'b0;
        step();                       // c=0
        step();                       // c=1
        div_enable = 1'b0;
        step();
        check("dis_run", 32'(running), 0);
        check("dis_out", 32'(div_out), 0);
        step();
        step();
        check("dis_run2", 32'(running), 0);
        div_enable = 1'b1;
        step();
        check("en_run", 32'(running), 1);
        for (int i = 0; i < 4; i++) begin
            check("en_out",  32'(div_out), 32'(pat4[i]));
            check("en_tick", 32'(div_tick), (i == 0) ? 32'd1 : 32'd0);
            step();
        end

        // Load on the wrap edge waits for the following wrap.
        repeat (3) step();            // c=3
        ratio_in   = 32'd6;
        ratio_load = 1'b1;
        step();                       // c=0
        ratio_load = 1'b0;
        check("ww_noack",  32'(ratio_ack), 0);
        check("ww_keep4",  active_ratio, 4);
        check("ww_tick",   32'(div_tick), 1);
        repeat (4) step();
        check("ww_ack",    32'(ratio_ack), 1);
        check("ww_active", active_ratio, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
